// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over
// a valid/ready request + valid response port, and computes the next PC on handoff.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic [1:0]  next_pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] imm_target,
  input  logic [31:0] jalr_target,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
`ifdef FETCH_MISALIGN_CHK_EN
    , S_FAULT = 2'b11
`endif
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        req_valid_r;
  logic        instr_valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_out_r;
  logic        misalign_r;
  logic [31:0] seq_pc_s;
  logic [31:0] raw_next_pc_s;
  logic [31:0] next_pc_s;
  logic        misaligned_s;

  assign seq_pc_s = pc_out_r + 32'd4;

  // Next-PC selection; JALR target has bit 0 cleared.
  always_comb begin
    raw_next_pc_s = seq_pc_s;
    case (next_pc_sel)
      2'b00:   raw_next_pc_s = seq_pc_s;
      2'b01:   raw_next_pc_s = branch_taken ? imm_target : seq_pc_s;
      2'b10:   raw_next_pc_s = imm_target;
      2'b11:   raw_next_pc_s = jalr_target & 32'hFFFF_FFFE;
      default: raw_next_pc_s = seq_pc_s;
    endcase
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign next_pc_s    = raw_next_pc_s;
  assign misaligned_s = (raw_next_pc_s[1:0] != 2'b00);
`else
  // Without the trap, low bits are simply dropped so fetch stays word-aligned.
  assign next_pc_s    = raw_next_pc_s & 32'hFFFF_FFFC;
  assign misaligned_s = 1'b0;
`endif

  // Fetch FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_REQ;
      pc_r          <= RESET_PC;
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
      instr_r       <= NOP_INSTR;
      pc_out_r      <= RESET_PC;
      misalign_r    <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          if (req_valid_r && imem_req_ready) begin
            state_r     <= S_WAIT;
            req_valid_r <= 1'b0;
          end else begin
            req_valid_r <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_r       <= imem_rsp_data;
            pc_out_r      <= pc_r;
            instr_valid_r <= 1'b1;
            state_r       <= S_HOLD;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (instr_valid_r && instr_ready) begin
            pc_r          <= next_pc_s;
            instr_valid_r <= 1'b0;
            instr_r       <= NOP_INSTR;
            if (misaligned_s) begin
`ifdef FETCH_MISALIGN_CHK_EN
              state_r    <= S_FAULT;
              misalign_r <= 1'b1;
`else
              state_r     <= S_REQ;
              req_valid_r <= 1'b1;
`endif
            end else begin
              state_r     <= S_REQ;
              req_valid_r <= 1'b1;
            end
          end else begin
            state_r <= S_HOLD;
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        // Only reset leaves the fault state.
        S_FAULT: begin
          req_valid_r   <= 1'b0;
          instr_valid_r <= 1'b0;
        end
`endif
        default: begin
          state_r       <= S_REQ;
          req_valid_r   <= 1'b0;
          instr_valid_r <= 1'b0;
          instr_r       <= NOP_INSTR;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign pc_out         = pc_out_r;
  assign opcode         = instr_r[6:0];
  assign funct3         = instr_r[14:12];
  assign funct7         = instr_r[31:25];
  assign misalign_err   = misalign_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs change 1ns after the
// rising edge and outputs are sampled there too.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  next_pc_sel;
  logic        branch_taken;
  logic [31:0] imm_target;
  logic [31:0] jalr_target;
  logic        misalign_err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc_out         (pc_out),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .next_pc_sel    (next_pc_sel),
    .branch_taken   (branch_taken),
    .imm_target     (imm_target),
    .jalr_target    (jalr_target),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, accept it, return word one cycle later, check the held instruction.
  task automatic get_instr(input logic [31:0] exp_addr, input logic [31:0] word);
    int n;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("imem_addr", imem_addr, exp_addr);
    step();
    check("req_drop", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, word);
    check("pc_out", pc_out, exp_addr);
  endtask

  task automatic consume(input logic [1:0] sel, input logic taken,
                         input logic [31:0] imm, input logic [31:0] jalr);
    next_pc_sel  = sel;
    branch_taken = taken;
    imm_target   = imm;
    jalr_target  = jalr;
    instr_ready  = 1'b1;
    step();
    instr_ready  = 1'b0;
    check("valid_clr", {31'd0, instr_valid}, 32'd0);
    check("instr_nop", instr, NOP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    instr_ready    = 1'b0;
    next_pc_sel    = 2'b00;
    branch_taken   = 1'b0;
    imm_target     = 32'h0000_0000;
    jalr_target    = 32'h0000_0000;

    // 1: reset values, first fetch and decode slices
    step();
    step();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc_out", pc_out, 32'h0000_0000);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    step();
    check("first_req", {31'd0, imem_req_valid}, 32'd1);
    get_instr(32'h0000_0000, 32'h0050_0093);
    check("opcode", {25'd0, opcode}, 32'h0000_0013);
    check("funct3", {29'd0, funct3}, 32'd0);
    check("funct7", {25'd0, funct7}, 32'd0);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    check("req_n3", {31'd0, imem_req_valid}, 32'd1);

    // 2: sequential fetches
    get_instr(32'h0000_0004, 32'h0010_0113);
    check("funct7_b", {25'd0, funct7}, 32'd0);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    get_instr(32'h0000_0008, 32'h4020_81B3);
    check("funct7_sub", {25'd0, funct7}, 32'h0000_0020);
    check("opcode_r", {25'd0, opcode}, 32'h0000_0033);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    get_instr(32'h0000_000C, 32'h0000_0013);
    consume(2'b00, 1'b0, 32'h0, 32'h0);

    // 3: branch not taken then taken
    get_instr(32'h0000_0010, 32'h0020_8463);
    check("funct3_beq", {29'd0, funct3}, 32'd0);
    consume(2'b01, 1'b0, 32'h0000_0040, 32'h0);
    get_instr(32'h0000_0014, 32'h0020_9463);
    check("funct3_bne", {29'd0, funct3}, 32'd1);
    consume(2'b01, 1'b1, 32'h0000_0040, 32'h0);

    // 4a: JALR clears bit 0; JAL to top of memory; sequential wrap to 0
    get_instr(32'h0000_0040, 32'h0000_8067);
    consume(2'b11, 1'b1, 32'h0000_0999, 32'h0000_0105);
    get_instr(32'h0000_0104, 32'h0000_006F);
    consume(2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0000_0105);
    get_instr(32'hFFFF_FFFC, 32'h0000_0013);
    consume(2'b00, 1'b1, 32'h0000_0040, 32'h0000_0105);

    // 5: request backpressure, then instruction backpressure with a stray response
    get_instr(32'h0000_0000, 32'h0000_0013);
    imem_req_ready = 1'b0;
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("bp_addr", imem_addr, 32'h0000_0004);
      step();
    end
    imem_req_ready = 1'b1;
    get_instr(32'h0000_0004, 32'h00A0_0513);
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = (i == 2);
      imem_rsp_data  = 32'hBAD0_BAD0;
      step();
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'h00A0_0513);
      check("hold_pc", pc_out, 32'h0000_0004);
      check("hold_noreq", {31'd0, imem_req_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b0;
    consume(2'b00, 1'b0, 32'h0, 32'h0);

    // 4b: JAL to a misaligned target
    get_instr(32'h0000_0008, 32'h0000_006F);
    consume(2'b10, 1'b0, 32'h0000_0102, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      check("fault_err", {31'd0, misalign_err}, 32'd1);
      check("fault_noreq", {31'd0, imem_req_valid}, 32'd0);
      check("fault_novalid", {31'd0, instr_valid}, 32'd0);
      step();
    end
    check("fault_pc", imem_addr, 32'h0000_0102);
`else
    check("no_misalign", {31'd0, misalign_err}, 32'd0);
    get_instr(32'h0000_0100, 32'h0000_0013);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
`endif

    // 6: reset during WAIT, stray response right after release
    rst_n = 1'b0;
    step();
    check("rst2_misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    step();
    check("rst2_req", {31'd0, imem_req_valid}, 32'd1);
    step();
    check("in_wait", {31'd0, imem_req_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("async_rst_addr", imem_addr, 32'h0000_0000);
    check("async_rst_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    imem_rsp_valid = 1'b0;
    check("stray_valid", {31'd0, instr_valid}, 32'd0);
    check("stray_instr", instr, NOP);
    check("restart_addr", imem_addr, 32'h0000_0000);
    get_instr(32'h0000_0000, 32'h0030_0193);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    get_instr(32'h0000_0004, 32'h0000_0013);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
